// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the Sysbus stage clients and bus_arbiter_rr.
// slave is the arbiter side, master is the client/bus side.
interface bus_arbiter_rr_if #(
  parameter int NUM_REQ = 6
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] in_reqcyc;
  logic               in_bus_busy;
  logic [NUM_REQ-1:0] out_grant;
  logic               out_grant_valid;
  logic [ID_W-1:0]    out_grant_id;
  logic               out_timeout_pulse;
  logic [15:0]        out_timeout_count;

  modport slave (
    input  in_reqcyc,
    input  in_bus_busy,
    output out_grant,
    output out_grant_valid,
    output out_grant_id,
    output out_timeout_pulse,
    output out_timeout_count
  );

  modport master (
    output in_reqcyc,
    output in_bus_busy,
    input  out_grant,
    input  out_grant_valid,
    input  out_grant_id,
    input  out_timeout_pulse,
    input  out_timeout_count
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-way Sysbus arbiter: fixed-priority or round-robin winner selection, grant held
// while bus_busy, and a watchdog that revokes grants the owner never used.
module bus_arbiter_rr #(
  parameter int NUM_REQ       = 6,
  parameter int RR_MODE       = 1,
  parameter int GRANT_TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  bus_arbiter_rr_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GRANT_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_RELEASE
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id, grant_id_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic               timeout_pulse, timeout_pulse_d;
  logic [15:0]        timeout_count, timeout_count_d;

  logic [ID_W-1:0]    winner;
  logic               found;

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    logic [ID_W-1:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
      cand = ID_W'(((RR_MODE != 0 ? 32'(rr_ptr) : 32'd0) + k) % unsigned'(NUM_REQ));
      if (!found && bus.in_reqcyc[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state;
    grant_d         = grant_q;
    grant_id_d      = grant_id;
    rr_ptr_d        = rr_ptr;
    timer_d         = timer;
    timeout_pulse_d = 1'b0;
    timeout_count_d = timeout_count;

    case (state)
      S_IDLE: begin
        if (found && !bus.in_bus_busy) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          grant_id_d      = winner;
          timer_d         = '0;
          state_d         = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.in_bus_busy) begin
          state_d = S_BUSY;
        end else if (!bus.in_reqcyc[grant_id]) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end else if (GRANT_TIMEOUT != 0 && timer == TMR_LAST) begin
          grant_d         = '0;
          state_d         = S_RELEASE;
          timeout_pulse_d = 1'b1;
          if (timeout_count != '1) timeout_count_d = timeout_count + 16'd1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_BUSY: begin
        if (!bus.in_bus_busy) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (RR_MODE != 0) rr_ptr_d = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      grant_q       <= '0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_d;
      grant_q       <= grant_d;
      grant_id      <= grant_id_d;
      rr_ptr        <= rr_ptr_d;
      timer         <= timer_d;
      timeout_pulse <= timeout_pulse_d;
      timeout_count <= timeout_count_d;
    end
  end

  assign bus.out_grant         = grant_q;
  assign bus.out_grant_valid   = |grant_q;
  assign bus.out_grant_id      = grant_id;
  assign bus.out_timeout_pulse = timeout_pulse;
  assign bus.out_timeout_count = timeout_count;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a round-robin/watchdog instance and a fixed-priority/no-watchdog
// instance share stimulus and are both tracked by an owner-based behavioural model.
module tb_bus_arbiter_rr;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         busy = 1'b0;
  bit           chk_en = 1'b0;
  int           errors = 0;
  int           checks = 0;

  bus_arbiter_rr_if #(.NUM_REQ(N)) bus_a ();
  bus_arbiter_rr_if #(.NUM_REQ(N)) bus_b ();

  assign bus_a.in_reqcyc   = req;
  assign bus_a.in_bus_busy = busy;
  assign bus_b.in_reqcyc   = req;
  assign bus_b.in_bus_busy = busy;

  bus_arbiter_rr #(.NUM_REQ(N), .RR_MODE(1), .GRANT_TIMEOUT(4)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a));
  bus_arbiter_rr #(.NUM_REQ(N), .RR_MODE(0), .GRANT_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b));

  always #5 clk = ~clk;

  // Model: who owns the bus (-1 none), whether the owner has gone busy, and a pending gap.
  int          m_mode[2] = '{1, 0};
  int          m_to[2]   = '{4, 0};
  int          m_own[2], m_gap[2], m_lock[2], m_tmr[2], m_ptr[2], m_id[2], m_pulse[2];
  logic [15:0] m_cnt[2];

  function automatic int pick(int i);
    int base = (m_mode[i] != 0) ? m_ptr[i] : 0;
    for (int k = 0; k < N; k++) begin
      int j = (base + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic drop_owner(int i);
    m_own[i] = -1;
    m_gap[i] = 1;
  endtask

  task automatic model_step(int i);
    if (rst) begin
      m_own[i] = -1; m_gap[i] = 0; m_lock[i] = 0; m_tmr[i] = 0;
      m_ptr[i] = 0; m_id[i] = 0; m_cnt[i] = '0; m_pulse[i] = 0;
      return;
    end
    m_pulse[i] = 0;
    if (m_own[i] >= 0) begin
      if (m_lock[i] != 0) begin
        if (!busy) drop_owner(i);
      end else if (busy) m_lock[i] = 1;
      else if (!req[m_own[i]]) drop_owner(i);
      else if (m_to[i] != 0 && m_tmr[i] == m_to[i] - 1) begin
        drop_owner(i);
        m_pulse[i] = 1;
        if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
      end else m_tmr[i]++;
    end else if (m_gap[i] != 0) begin
      m_gap[i] = 0;
      if (m_mode[i] != 0) m_ptr[i] = (m_id[i] + 1) % N;
    end else if (req != 0 && !busy) begin
      m_own[i] = pick(i);
      m_id[i] = m_own[i];
      m_tmr[i] = 0;
      m_lock[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_grant(int i);
    return (m_own[i] >= 0) ? (32'd1 << m_own[i]) : 32'd0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_grant", 32'(bus_a.out_grant), exp_grant(0));
      chk("a_valid", 32'(bus_a.out_grant_valid), 32'(m_own[0] >= 0));
      chk("a_id", 32'(bus_a.out_grant_id), 32'(m_id[0]));
      chk("a_pulse", 32'(bus_a.out_timeout_pulse), 32'(m_pulse[0]));
      chk("a_count", 32'(bus_a.out_timeout_count), 32'(m_cnt[0]));
      chk("b_grant", 32'(bus_b.out_grant), exp_grant(1));
      chk("b_valid", 32'(bus_b.out_grant_valid), 32'(m_own[1] >= 0));
      chk("b_id", 32'(bus_b.out_grant_id), 32'(m_id[1]));
      chk("b_count", 32'(bus_b.out_timeout_count), 32'(m_cnt[1]));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant_a();
    int n = 0;
    while (bus_a.out_grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait_bound", 32'(n < 50), 32'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_grant", 32'(bus_a.out_grant), 32'd0);
    chk("rst_valid", 32'(bus_a.out_grant_valid), 32'd0);
    chk("rst_id", 32'(bus_a.out_grant_id), 32'd0);
    chk("rst_count", 32'(bus_a.out_timeout_count), 32'd0);
    rst = 1'b0;

    // Watchdog: req[2] alone, busy never asserted.
    req = 6'b000100;
    @(negedge clk);
    chk("to_first_grant", 32'(bus_a.out_grant), 32'h04);
    n = 0;
    while (bus_a.out_grant == 6'b000100 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("to_grant_cycles", 32'(n), 32'd4);
    chk("to_pulse", 32'(bus_a.out_timeout_pulse), 32'd1);
    chk("to_count", 32'(bus_a.out_timeout_count), 32'd1);
    chk("to_b_held", 32'(bus_b.out_grant), 32'h04);
    @(negedge clk);
    chk("to_pulse_once", 32'(bus_a.out_timeout_pulse), 32'd0);
    chk("to_gap2", 32'(bus_a.out_grant), 32'd0);
    @(negedge clk);
    chk("to_regrant", 32'(bus_a.out_grant), 32'h04);

    // Reset during BUSY (count is 1 here, must clear).
    req = '0;
    repeat (4) @(negedge clk);
    req = 6'b000010;
    @(negedge clk);
    chk("rb_grant1", 32'(bus_a.out_grant), 32'h02);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rb_busy_held", 32'(bus_a.out_grant), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_grant0", 32'(bus_a.out_grant), 32'd0);
    chk("rb_id0", 32'(bus_a.out_grant_id), 32'd0);
    chk("rb_count0", 32'(bus_a.out_timeout_count), 32'd0);
    rst = 1'b0; busy = 1'b0; req = 6'b010000;
    @(negedge clk);
    chk("rb_fresh_grant", 32'(bus_a.out_grant), 32'h10);
    chk("rb_fresh_id", 32'(bus_a.out_grant_id), 32'd4);

    // Two requesters, one busy pulse per grant: RR alternates, fixed priority starves req[5].
    do_reset();
    req = 6'b100001;
    for (int g = 0; g < 4; g++) begin
      wait_grant_a();
      chk("rr_id", 32'(bus_a.out_grant_id), (g % 2 != 0) ? 32'd5 : 32'd0);
      chk("fp_id", 32'(bus_b.out_grant), 32'h01);
      busy = 1'b1;
      @(negedge clk);
      busy = 1'b0;
      @(negedge clk);
      n = 0;
      while (bus_a.out_grant == '0 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("rr_gap", 32'(n), 32'd2);
    end
    chk("rr_no_timeouts", 32'(bus_a.out_timeout_count), 32'd0);

    // Grant held through busy even after the owner withdraws.
    do_reset();
    req = 6'b001000;
    @(negedge clk);
    chk("hold_grant", 32'(bus_a.out_grant), 32'h08);
    busy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) req = '0;
      chk("hold_busy", 32'(bus_a.out_grant), 32'h08);
    end
    busy = 1'b0;
    @(negedge clk);
    chk("hold_release", 32'(bus_a.out_grant), 32'd0);

    // Busy in IDLE blocks any grant.
    do_reset();
    busy = 1'b1; req = 6'b000010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_busy_nogrant", 32'(bus_a.out_grant), 32'd0);
    end
    busy = 1'b0;
    @(negedge clk);
    chk("idle_busy_grant", 32'(bus_a.out_grant), 32'h02);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      busy = ($urandom_range(0, 3) == 0);
    end

    // Counter saturation: preload near max, then force many watchdog revokes.
    do_reset();
    @(posedge clk);
    #1;
    force dut_a.timeout_count = 16'hFF00;
    m_cnt[0] = 16'hFF00;
    @(posedge clk);
    #1;
    release dut_a.timeout_count;
    @(negedge clk);
    req = 6'b111111;
    repeat (2000) @(negedge clk);
    chk("sat_count", 32'(bus_a.out_timeout_count), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
